fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Parametrised instruction-fetch stage for the RISC-V core. Successor to the single-register fetch stage.
- Issues pipelined requests to an instruction memory over a req/gnt/rvalid handshake and buffers returned words in a FQ_DEPTH-entry fetch queue.
- Presents the queue head to decode as op/rs1/rs2/rd/imm with a valid/ready handshake.
- Supports branch redirect with flush of the queue and of in-flight responses.

Parameters:
- XLEN, 32, address and instruction width; must be 32.
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.
- FQ_DEPTH, 4, fetch-queue entries and maximum outstanding requests; power of two, 2..16.

Ports:
- clock  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  XLEN  fetch address (current PC).
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response word valid; responses return in order, at least 1 cycle after gnt.
- imem_rdata  in  XLEN  response instruction word.
- d_ready  in  1  decode accepts the head instruction.
- br_en  in  1  redirect request.
- br_addr  in  XLEN  redirect target.
- f_valid  out  1  head instruction valid.
- f_pc  out  XLEN  PC of the head instruction.
- op  out  7  head instr[6:0].
- rs1  out  5  head instr[19:15].
- rs2  out  5  head instr[24:20].
- rd  out  5  head instr[11:7].
- imm  out  12  head instr[31:20].

Behaviour:
- Reset (asynchronous):
  - PC = RESET_PC; queue empty; outstanding = 0; discard = 0.
  - imem_req = 0, f_valid = 0, all field outputs 0, f_pc = 0.
- Credits: imem_req = !br_en && (count + outstanding < FQ_DEPTH). The queue can never overflow.
- Request: imem_addr = PC. Address is held stable while imem_req=1 && !imem_gnt. On imem_req && imem_gnt: PC <= PC + 4 (wraps modulo 2^32) and outstanding increments.
- Response: each imem_rvalid decrements outstanding.
  - If discard > 0: the word is dropped and discard decrements.
  - Otherwise {PC-tag, word} is written at the tail. The tag is the issue PC, kept in a parallel FQ_DEPTH-entry tag FIFO written on gnt.
- Simultaneous gnt and rvalid: outstanding is unchanged.
- Decode handshake:
  - f_valid = queue not empty.
  - Pop on f_valid && d_ready. Push and pop in the same cycle are allowed, including when full.
  - Fields and f_pc come combinationally from the head entry, and are 0 when empty.
- Redirect (br_en=1), takes effect at the next edge:
  - PC <= {br_addr[31:2], 2'b00}; queue and tag FIFO cleared.
  - discard <= outstanding after this cycle's gnt/rvalid updates.
  - br_en has priority over pop, push and PC increment in the same cycle.
  - A gnt in the br_en cycle cannot occur because imem_req is 0.
- Back-to-back br_en: the latest target wins; discard accumulates correctly.
- Latency: request at cycle N, rvalid at N+k gives f_valid at N+k+1 (registered queue write).
- Invariant: discard <= outstanding <= FQ_DEPTH. An assertion flags any violation.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined: adds output ports fetch_stall_cnt (32) and fetch_flush_cnt (32).
  - fetch_stall_cnt increments each cycle with d_ready && !f_valid.
  - fetch_flush_cnt increments each br_en cycle.
  - Both are reset to 0 and saturate at 32'hFFFF_FFFF.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg holds:
  - RISC-V field bit-position constants (OP_LSB/MSB, RS1_LSB, RS2_LSB, RD_LSB, IMM_LSB).
  - typedef fq_entry_t {logic [31:0] pc; logic [31:0] instr;}.
  - Constant INSTR_BYTES = 4.
- One sub-module, fetch_queue: a synchronous FIFO parametrised on FQ_DEPTH and entry type.
  - Provides push, pop, flush, count, full and empty.
  - The top instantiates it for entries and, separately or combined, for tags.

Test Plan:
- Reset then imem_gnt=1, 1-cycle rvalid, d_ready=1 -> imem_addr 0,4,8,...; f_pc sequence 0,4,8; op/rd/rs1 match rdata slices; f_valid first high 2 cycles after the first gnt.
- d_ready=0 with memory always granting (FQ_DEPTH=4) -> exactly 4 grants then imem_req=0; f_valid=1 holding PC 0. Release d_ready -> requests resume one per pop.
- 2 requests in flight, br_en=1 with br_addr=32'h100 -> both late responses dropped; next f_pc=32'h100; imem_addr=32'h100 one cycle after br_en.
- br_en in the same cycle as pop and rvalid, with queue holding 3 -> queue empty next cycle; no stale f_valid; discard count is correct.
- br_addr=32'h203 -> PC=32'h200. PC=32'hFFFF_FFFC granted -> PC wraps to 0.
- FETCH_PERF_CNT_EN defined: 5 starved cycles with d_ready=1 and 2 br_en pulses -> stall_cnt=5, flush_cnt=2; mid-run reset -> both 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: RISC-V field
// positions, the fetch-queue entry layout and PC alignment helper.
package fetch_pkg;

   // RISC-V base-format field positions within a 32-bit instruction
   localparam int OP_LSB  = 0;
   localparam int OP_MSB  = 6;
   localparam int RD_LSB  = 7;
   localparam int RS1_LSB = 15;
   localparam int RS2_LSB = 20;
   localparam int IMM_LSB = 20;

   localparam int OP_W  = 7;
   localparam int REG_W = 5;
   localparam int IMM_W = 12;

   localparam int INSTR_BYTES = 4;

   // One buffered instruction together with the PC it was fetched from
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fq_entry_t;

   // Clear the low bits so a redirect target is always instruction aligned
   function automatic logic [31:0] align_pc(input logic [31:0] a);
      return a & ~32'(INSTR_BYTES - 1);
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush, parameterised on depth (power of two) and
// entry type. Push while full is accepted only together with a pop.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = logic [31:0],
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  T              wdata,
   output T              rdata,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   T              mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   // Pointer and occupancy tracking; flush empties the queue in one edge
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage array; contents need no reset since count gates visibility
   always_ff @(posedge clock) begin
      if (do_push && !flush) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/fetch_unit.sv
// Pipelined instruction-fetch stage. Issues credit-limited requests over a
// req/gnt/rvalid handshake, tags each grant with its PC, buffers returned
// words and presents the head instruction to decode. A redirect flushes the
// queue and drops every response still in flight.
// Optional feature macro: FETCH_PERF_CNT_EN (stall / flush counters).
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int          XLEN     = 32,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          FQ_DEPTH = 4
) (
   input  logic            clock,
   input  logic            reset,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            d_ready,
   input  logic            br_en,
   input  logic [XLEN-1:0] br_addr,
   output logic            f_valid,
   output logic [XLEN-1:0] f_pc,
   output logic [6:0]      op,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [4:0]      rd,
   output logic [11:0]     imm
`ifdef FETCH_PERF_CNT_EN
  ,output logic [31:0]     fetch_stall_cnt,
   output logic [31:0]     fetch_flush_cnt
`endif
);

   localparam int          CW      = $clog2(FQ_DEPTH + 1);
   localparam logic [CW:0] DEPTH_C = (CW+1)'(FQ_DEPTH);

   logic [XLEN-1:0] pc;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   discard;
   logic [CW-1:0]   out_nxt;
   logic [CW-1:0]   q_count;
   logic [CW-1:0]   tag_count;
   logic            q_full, q_empty;
   logic            tag_full, tag_empty;
   fq_entry_t       q_wdata, q_head;
   logic [31:0]     tag_head;
   logic            gnt_fire, resp_keep, q_push, q_pop;

   // Credits cover both buffered words and words still on the way back,
   // so the queue can never be asked to take more than it holds.
   assign imem_req  = !reset && !br_en &&
                      (({1'b0, q_count} + {1'b0, outstanding}) < DEPTH_C);
   assign imem_addr = pc;
   assign gnt_fire  = imem_req && imem_gnt;
   assign resp_keep = imem_rvalid && (discard == '0);
   assign out_nxt   = outstanding + CW'(gnt_fire) - CW'(imem_rvalid);

   // Redirect wins over both queue push and pop in the same cycle
   assign q_push  = resp_keep && !br_en;
   assign q_pop   = !q_empty && d_ready && !br_en;
   assign q_wdata = '{pc: tag_head, instr: imem_rdata};

   // Issue-PC tags: written on grant, consumed by each kept response
   fetch_queue #(.DEPTH(FQ_DEPTH), .T(logic [31:0])) u_tag_q (
      .clock (clock),
      .reset (reset),
      .push  (gnt_fire),
      .pop   (resp_keep),
      .flush (br_en),
      .wdata (pc),
      .rdata (tag_head),
      .count (tag_count),
      .full  (tag_full),
      .empty (tag_empty)
   );

   // Instruction queue holding {pc, word} pairs for decode
   fetch_queue #(.DEPTH(FQ_DEPTH), .T(fq_entry_t)) u_instr_q (
      .clock (clock),
      .reset (reset),
      .push  (q_push),
      .pop   (q_pop),
      .flush (br_en),
      .wdata (q_wdata),
      .rdata (q_head),
      .count (q_count),
      .full  (q_full),
      .empty (q_empty)
   );

   // PC, in-flight and drop-count bookkeeping
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc          <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
      end else begin
         outstanding <= out_nxt;
         if (br_en) begin
            pc      <= align_pc(br_addr);
            // Everything still in flight after this edge belongs to the
            // old path and must be dropped when it returns.
            discard <= out_nxt;
         end else begin
            if (gnt_fire) pc <= pc + XLEN'(INSTR_BYTES);
            if (imem_rvalid && (discard != '0)) discard <= discard - 1'b1;
         end
      end
   end

   // Decode view of the queue head; all zero while the queue is empty
   always_comb begin
      f_valid = !q_empty;
      f_pc    = '0;
      op      = '0;
      rs1     = '0;
      rs2     = '0;
      rd      = '0;
      imm     = '0;
      if (!q_empty) begin
         f_pc = q_head.pc;
         op   = q_head.instr[OP_MSB:OP_LSB];
         rd   = q_head.instr[RD_LSB  +: REG_W];
         rs1  = q_head.instr[RS1_LSB +: REG_W];
         rs2  = q_head.instr[RS2_LSB +: REG_W];
         imm  = q_head.instr[IMM_LSB +: IMM_W];
      end
   end

`ifdef FETCH_PERF_CNT_EN
   // Saturating counters: decode starved cycles and redirect cycles
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fetch_stall_cnt <= '0;
         fetch_flush_cnt <= '0;
      end else begin
         if (d_ready && q_empty && (fetch_stall_cnt != '1))
            fetch_stall_cnt <= fetch_stall_cnt + 1'b1;
         if (br_en && (fetch_flush_cnt != '1))
            fetch_flush_cnt <= fetch_flush_cnt + 1'b1;
      end
   end
`else
   // Performance counters are not built in this configuration.
`endif

   // Bookkeeping sanity: drops never exceed in-flight, in-flight never
   // exceeds the credit limit, and tags line up with kept responses.
   a_credit : assert property (@(posedge clock) disable iff (reset)
      (discard <= outstanding) && (outstanding <= CW'(FQ_DEPTH)));
   a_tags : assert property (@(posedge clock) disable iff (reset)
      (tag_count == (outstanding - discard)) && !(tag_full && imem_req));
   a_tag_avail : assert property (@(posedge clock) disable iff (reset)
      !(resp_keep && tag_empty));
   a_no_ovf : assert property (@(posedge clock) disable iff (reset)
      !(q_push && q_full && !q_pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit with a transaction-level reference model:
// a queue of delivered instructions, a queue of in-flight fetches marked
// dead on redirect, and a model PC.
module tb_fetch_unit;

   localparam int FQ = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        d_ready;
   logic        br_en;
   logic [31:0] br_addr;
   logic        f_valid;
   logic [31:0] f_pc;
   logic [6:0]  op;
   logic [4:0]  rs1, rs2, rd;
   logic [11:0] imm;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_stall_cnt, fetch_flush_cnt;
`endif

   fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FQ_DEPTH(FQ)) dut (
      .clock       (clock),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .d_ready     (d_ready),
      .br_en       (br_en),
      .br_addr     (br_addr),
      .f_valid     (f_valid),
      .f_pc        (f_pc),
      .op          (op),
      .rs1         (rs1),
      .rs2         (rs2),
      .rd          (rd),
      .imm         (imm)
`ifdef FETCH_PERF_CNT_EN
     ,.fetch_stall_cnt (fetch_stall_cnt),
      .fetch_flush_cnt (fetch_flush_cnt)
`endif
   );

   always #5 clock = ~clock;

   typedef struct { logic [31:0] addr; bit dead; } fl_t;
   typedef struct { logic [31:0] pc; logic [31:0] instr; } me_t;

   me_t         mq[$];
   fl_t         fl[$];
   logic [31:0] mpc;
   int          n_cmp = 0;
   int          n_err = 0;
   int          m_stall = 0;
   int          m_flush = 0;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: drive at negedge, check outputs, advance model at posedge
   task automatic cycle(input bit g, input bit rv_ok, input bit dr,
                        input bit br, input logic [31:0] ba);
      bit          exp_req, rv, pop_ok, keep;
      logic [31:0] w, ra;
      @(negedge clock);
      rv          = rv_ok && (fl.size() > 0);
      imem_gnt    = g;
      d_ready     = dr;
      br_en       = br;
      br_addr     = ba;
      imem_rvalid = rv;
      imem_rdata  = rv ? word_at(fl[0].addr) : $urandom;
      #1;
      exp_req = !br && ((mq.size() + fl.size()) < FQ);
      chk("imem_req", imem_req, exp_req);
      if (exp_req) chk("imem_addr", imem_addr, mpc);
      chk("f_valid", f_valid, mq.size() > 0);
      w = (mq.size() > 0) ? mq[0].instr : 32'h0;
      chk("f_pc", f_pc, (mq.size() > 0) ? mq[0].pc : 32'h0);
      chk("op",  op,  w[6:0]);
      chk("rd",  rd,  w[11:7]);
      chk("rs1", rs1, w[19:15]);
      chk("rs2", rs2, w[24:20]);
      chk("imm", imm, w[31:20]);
`ifdef FETCH_PERF_CNT_EN
      chk("stall_cnt", fetch_stall_cnt, m_stall);
      chk("flush_cnt", fetch_flush_cnt, m_flush);
`endif
      @(posedge clock);
      pop_ok = (mq.size() > 0) && dr;
      keep   = 1'b0;
      ra     = '0;
      if (dr && (mq.size() == 0)) m_stall++;
      if (br) m_flush++;
      if (rv) begin
         ra   = fl[0].addr;
         keep = !fl[0].dead;
         void'(fl.pop_front());
      end
      if (br) begin
         mq.delete();
         foreach (fl[i]) fl[i].dead = 1'b1;
         mpc = ba & 32'hFFFF_FFFC;
      end else begin
         if (pop_ok) void'(mq.pop_front());
         if (keep) mq.push_back('{ra, word_at(ra)});
         if (exp_req && g) begin
            fl.push_back('{mpc, 1'b0});
            mpc = mpc + 32'd4;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      d_ready = 1'b0; br_en = 1'b0; br_addr = '0;
      mq.delete(); fl.delete();
      mpc = 32'h0; m_stall = 0; m_flush = 0;
      #1;
      chk("rst_req",   imem_req, 32'h0);
      chk("rst_valid", f_valid,  32'h0);
      chk("rst_pc",    f_pc,     32'h0);
      chk("rst_op",    op,       32'h0);
      chk("rst_imm",   imm,      32'h0);
`ifdef FETCH_PERF_CNT_EN
      chk("rst_stall", fetch_stall_cnt, 32'h0);
      chk("rst_flush", fetch_flush_cnt, 32'h0);
`endif
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      d_ready = 1'b0; br_en = 1'b0; br_addr = '0;

      // Streaming: always grant, one-cycle responses, decode always ready
      do_reset();
      for (int i = 0; i < 12; i++) cycle(1, 1, 1, 0, 0);

      // Decode stalled: credits run out after FQ grants, then resume
      do_reset();
      for (int i = 0; i < 10; i++) cycle(1, 1, 0, 0, 0);
      chk("stall_req", imem_req, 32'h0);
      for (int i = 0; i < 8; i++) cycle(1, 1, 1, 0, 0);

      // Redirect with two requests in flight; late responses dropped
      do_reset();
      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      cycle(0, 0, 0, 1, 32'h100);
      #1 chk("br_target", imem_addr, 32'h100);
      for (int i = 0; i < 6; i++) cycle(1, 1, 1, 0, 0);

      // Redirect coinciding with pop and response while queue holds 3
      do_reset();
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);
      cycle(0, 1, 1, 1, 32'h40);
      #1 chk("br_empty", f_valid, 32'h0);
      for (int i = 0; i < 6; i++) cycle(1, 1, 1, 0, 0);

      // Unaligned target and PC wrap at the top of the address space
      cycle(0, 1, 1, 1, 32'h203);
      #1 chk("br_align", imem_addr, 32'h200);
      cycle(0, 1, 1, 1, 32'hFFFF_FFFC);
      cycle(1, 0, 1, 0, 0);
      #1 chk("pc_wrap", imem_addr, 32'h0);
      for (int i = 0; i < 6; i++) cycle(1, 1, 1, 0, 0);

      // Random traffic with occasional redirects and mid-run resets
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if (($urandom % 700) == 0) do_reset();
         cycle(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 4) != 0,
               ($urandom % 16) == 0, $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
